// File: rtl/amplitude_monitor.sv
// amplitude_monitor: measures the signed maximum, minimum and peak-to-peak
// span of a qualified sample stream over a requested window of valid samples.
// After start, SETTLE_SAMPLES valid samples are discarded to absorb upstream
// filter group delay. The next window_length valid samples are then measured,
// and the result is presented for one REPORT cycle.
//
// Stream semantics: data is consumed on any rising edge where data_valid=1.
// There is no backpressure. The source never stalls, and the monitor never
// refuses a sample. A cycle with data_valid=0 changes no counter and no
// running value. start is a single-cycle request that is honoured only in
// IDLE and is dropped silently in every other state.
//
// Counter width: SETTLE_SAMPLES must fit in COUNT_WIDTH bits.
module amplitude_monitor #(
  parameter int DATA_WIDTH     = 17,
  parameter int SETTLE_SAMPLES = 64,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] data,
  input  logic                         data_valid,
  input  logic                         start,
  input  logic [COUNT_WIDTH-1:0]       window_length,
  input  logic [DATA_WIDTH:0]          threshold,
  output logic                         busy,
  output logic signed [DATA_WIDTH-1:0] maximum,
  output logic signed [DATA_WIDTH-1:0] minimum,
  output logic [DATA_WIDTH:0]          peak_to_peak,
  output logic                         below_threshold,
  output logic                         result_valid,
  output logic [1:0]                   fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    REPORT  = 2'd3
  } state_t;

  // Index of the final settle sample.
  // It is unused when SETTLE_SAMPLES is 0, because SETTLE is then skipped.
  localparam logic [COUNT_WIDTH-1:0] SETTLE_LAST =
    COUNT_WIDTH'((SETTLE_SAMPLES == 0) ? 0 : SETTLE_SAMPLES - 1);

  state_t current_state;
  state_t next_state;

  // Settings latched when a start is accepted.
  logic [COUNT_WIDTH-1:0] window_last;
  logic [DATA_WIDTH:0]    threshold_reg;

  // Sample counters.
  logic [COUNT_WIDTH-1:0] settle_count;
  logic [COUNT_WIDTH-1:0] measure_count;

  // Running extremes of the window in progress.
  logic signed [DATA_WIDTH-1:0] run_max;
  logic signed [DATA_WIDTH-1:0] run_min;

  // Control strobes decoded from the state and the inputs.
  logic accept_start;
  logic settle_step;
  logic settle_done;
  logic measure_step;
  logic window_done;

  // Extremes that include the current sample, and the span derived from them.
  logic signed [DATA_WIDTH-1:0] next_max;
  logic signed [DATA_WIDTH-1:0] next_min;
  logic [DATA_WIDTH:0]          ext_max;
  logic [DATA_WIDTH:0]          ext_min;
  logic [DATA_WIDTH:0]          next_span;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      current_state <= IDLE;
    end else begin
      current_state <= next_state;
    end
  end

  // Next-state logic and control strobes.
  always_comb begin
    next_state   = current_state;
    accept_start = 1'b0;
    settle_step  = 1'b0;
    settle_done  = 1'b0;
    measure_step = 1'b0;
    window_done  = 1'b0;
    case (current_state)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          next_state   = (SETTLE_SAMPLES == 0) ? MEASURE : SETTLE;
        end
      end
      SETTLE: begin
        if (data_valid) begin
          settle_step = 1'b1;
          if (settle_count == SETTLE_LAST) begin
            settle_done = 1'b1;
            next_state  = MEASURE;
          end
        end
      end
      MEASURE: begin
        if (data_valid) begin
          measure_step = 1'b1;
          if (measure_count == window_last) begin
            window_done = 1'b1;
            next_state  = REPORT;
          end
        end
      end
      REPORT: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Fold the current sample into the running extremes.
  // The first measured sample loads both extremes.
  // Both operands are sign-extended by one bit so that the span cannot wrap.
  always_comb begin
    next_max = run_max;
    next_min = run_min;
    if (measure_count == '0 || data > run_max) begin
      next_max = data;
    end
    if (measure_count == '0 || data < run_min) begin
      next_min = data;
    end
    ext_max   = {next_max[DATA_WIDTH-1], next_max};
    ext_min   = {next_min[DATA_WIDTH-1], next_min};
    next_span = ext_max - ext_min;
  end

  // Latch settings on start, advance counters and running extremes,
  // and publish the result on the edge that accepts the final sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      window_last     <= '0;
      threshold_reg   <= '0;
      settle_count    <= '0;
      measure_count   <= '0;
      run_max         <= '0;
      run_min         <= '0;
      maximum         <= '0;
      minimum         <= '0;
      peak_to_peak    <= '0;
      below_threshold <= 1'b0;
      result_valid    <= 1'b0;
    end else begin
      result_valid <= window_done;
      if (accept_start) begin
        // A zero-length request is treated as a one-sample window.
        window_last   <= (window_length == '0) ? '0 : window_length - 1'b1;
        threshold_reg <= threshold;
        settle_count  <= '0;
        measure_count <= '0;
        run_max       <= '0;
        run_min       <= '0;
      end
      if (settle_step && !settle_done) begin
        settle_count <= settle_count + 1'b1;
      end else if (settle_done) begin
        settle_count <= '0;
      end
      if (measure_step) begin
        run_max       <= next_max;
        run_min       <= next_min;
        measure_count <= measure_count + 1'b1;
      end
      if (window_done) begin
        maximum         <= next_max;
        minimum         <= next_min;
        peak_to_peak    <= next_span;
        below_threshold <= (next_span < threshold_reg);
      end
    end
  end

  assign busy      = (current_state != IDLE);
  assign fsm_state = current_state;

endmodule

// File: tb/tb_amplitude_monitor.sv
// Directed testbench for amplitude_monitor (DATA_WIDTH=17, SETTLE_SAMPLES=4).
module tb_amplitude_monitor;

  localparam int DW = 17;
  localparam int CW = 16;
  localparam int SETTLE = 4;

  logic                 clock;
  logic                 reset;
  logic signed [DW-1:0] data;
  logic                 data_valid;
  logic                 start;
  logic [CW-1:0]        window_length;
  logic [DW:0]          threshold;
  logic                 busy;
  logic signed [DW-1:0] maximum;
  logic signed [DW-1:0] minimum;
  logic [DW:0]          peak_to_peak;
  logic                 below_threshold;
  logic                 result_valid;
  logic [1:0]           fsm_state;

  int tests_run = 0;
  int tests_failed = 0;
  int result_count = 0;
  int results_before;

  // Expected peak-to-peak value of each window that should complete.
  logic [DW:0] exp_q[$];

  amplitude_monitor #(
    .DATA_WIDTH(DW),
    .SETTLE_SAMPLES(SETTLE),
    .COUNT_WIDTH(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .data(data),
    .data_valid(data_valid),
    .start(start),
    .window_length(window_length),
    .threshold(threshold),
    .busy(busy),
    .maximum(maximum),
    .minimum(minimum),
    .peak_to_peak(peak_to_peak),
    .below_threshold(below_threshold),
    .result_valid(result_valid),
    .fsm_state(fsm_state)
  );

  // Clock generation.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_value(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    data_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic start_meas(input int wl, input int thr);
    start = 1'b1;
    window_length = CW'(wl);
    threshold = (DW + 1)'(thr);
    data_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic send_sample(input int d, input logic v);
    data = DW'(d);
    data_valid = v;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic settle_samples();
    for (int i = 0; i < SETTLE; i++) send_sample(20000 - i * 9000, 1'b1);
  endtask

  task automatic check_result(input string tag, input int mx, input int mn, input int span,
                              input int below);
    check_value({tag, "_valid"}, int'(result_valid), 1);
    check_value({tag, "_max"}, int'(maximum), mx);
    check_value({tag, "_min"}, int'(minimum), mn);
    check_value({tag, "_p2p"}, int'(peak_to_peak), span);
    check_value({tag, "_below"}, int'(below_threshold), below);
  endtask

  // Scoreboard: every result pulse must match the next expected window.
  always @(negedge clock) begin
    if (result_valid) begin
      result_count++;
      if (exp_q.size() == 0) begin
        check_value("sb_unexpected_result", 1, 0);
      end else begin
        check_value("sb_p2p", int'(peak_to_peak), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b0;
    data = '0;
    data_valid = 1'b0;
    start = 1'b0;
    window_length = '0;
    threshold = '0;

    // Reset state.
    do_reset();
    check_value("rst_busy", int'(busy), 0);
    check_value("rst_valid", int'(result_valid), 0);
    check_value("rst_max", int'(maximum), 0);
    check_value("rst_min", int'(minimum), 0);
    check_value("rst_p2p", int'(peak_to_peak), 0);
    check_value("rst_below", int'(below_threshold), 0);
    check_value("rst_state", int'(fsm_state), 0);

    // Basic window: settle samples are discarded, and 8 samples are measured.
    exp_q.push_back(18'd300);
    start_meas(8, 500);
    check_value("t1_busy", int'(busy), 1);
    settle_samples();
    send_sample(10, 1'b1);
    send_sample(-3, 1'b1);
    send_sample(7, 1'b1);
    send_sample(100, 1'b1);
    send_sample(-200, 1'b1);
    send_sample(50, 1'b1);
    send_sample(0, 1'b1);
    check_value("t1_early_valid", int'(result_valid), 0);
    send_sample(5, 1'b1);
    check_result("t1", 100, -200, 300, 1);
    check_value("t1_report_state", int'(fsm_state), 3);
    tick();
    check_value("t1_pulse_end", int'(result_valid), 0);
    check_value("t1_idle_busy", int'(busy), 0);
    check_value("t1_hold_max", int'(maximum), 100);

    // Full-scale span with no wrap, against a threshold just above it.
    exp_q.push_back(18'd131071);
    start_meas(2, 131072);
    settle_samples();
    send_sample(65535, 1'b1);
    send_sample(-65536, 1'b1);
    check_result("t2", 65535, -65536, 131071, 1);
    tick();

    // The same span against an equal threshold is not below it.
    exp_q.push_back(18'd131071);
    start_meas(2, 131071);
    settle_samples();
    send_sample(-65536, 1'b1);
    send_sample(65535, 1'b1);
    check_result("t2b", 65535, -65536, 131071, 0);
    tick();

    // data_valid toggles every other cycle, and invalid-cycle data is junk.
    exp_q.push_back(18'd20);
    start_meas(4, 0);
    for (int i = 0; i < SETTLE; i++) begin
      send_sample(30000, 1'b0);
      send_sample(i, 1'b1);
    end
    send_sample(3, 1'b1);
    send_sample(-30000, 1'b0);
    send_sample(-8, 1'b1);
    send_sample(30000, 1'b0);
    send_sample(12, 1'b1);
    send_sample(-30000, 1'b0);
    check_value("t3_gap_valid", int'(result_valid), 0);
    check_value("t3_gap_busy", int'(busy), 1);
    send_sample(1, 1'b1);
    check_result("t3", 12, -8, 20, 0);
    tick();

    // A zero window length is treated as a one-sample window.
    exp_q.push_back(18'd0);
    start_meas(0, 1);
    for (int i = 0; i < SETTLE; i++) send_sample(42, 1'b1);
    send_sample(42, 1'b1);
    check_result("t4", 42, 42, 0, 1);
    tick();

    // Reset mid-MEASURE abandons the window and clears the outputs.
    start_meas(8, 100);
    settle_samples();
    send_sample(-7, 1'b1);
    send_sample(70, 1'b1);
    send_sample(9, 1'b1);
    results_before = result_count;
    reset = 1'b1;
    start = 1'b1;
    data = DW'(500);
    data_valid = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    data_valid = 1'b0;
    check_value("t5_busy", int'(busy), 0);
    check_value("t5_valid", int'(result_valid), 0);
    check_value("t5_max", int'(maximum), 0);
    check_value("t5_min", int'(minimum), 0);
    check_value("t5_p2p", int'(peak_to_peak), 0);
    check_value("t5_below", int'(below_threshold), 0);
    check_value("t5_state", int'(fsm_state), 0);
    for (int i = 0; i < 5; i++) send_sample(i, 1'b1);
    check_value("t5_no_result", result_count, results_before);
    exp_q.push_back(18'd2);
    start_meas(3, 10);
    settle_samples();
    send_sample(5, 1'b1);
    send_sample(6, 1'b1);
    send_sample(7, 1'b1);
    check_result("t5_restart", 7, 5, 2, 1);
    tick();

    // Starts while busy and in REPORT are ignored.
    // A start in the following IDLE cycle is accepted.
    results_before = result_count;
    exp_q.push_back(18'd200);
    start_meas(3, 1000);
    start = 1'b1;
    window_length = CW'(1);
    threshold = '0;
    send_sample(1, 1'b1);
    start = 1'b0;
    for (int i = 1; i < SETTLE; i++) send_sample(i, 1'b1);
    send_sample(100, 1'b1);
    start = 1'b1;
    send_sample(-100, 1'b1);
    start = 1'b0;
    check_value("t6_len_kept", int'(result_valid), 0);
    send_sample(50, 1'b1);
    check_result("t6", 100, -100, 200, 1);
    // We are now in REPORT: this start must be dropped.
    start = 1'b1;
    window_length = CW'(1);
    threshold = '0;
    tick();
    check_value("t6_report_start", int'(busy), 0);
    // The start is still high in IDLE: this one is accepted.
    exp_q.push_back(18'd0);
    tick();
    start = 1'b0;
    check_value("t6_idle_start", int'(busy), 1);
    settle_samples();
    send_sample(9, 1'b1);
    check_result("t6b", 9, 9, 0, 0);
    tick();
    tick();
    check_value("t6_result_count", result_count - results_before, 2);

    check_value("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
